// File: rtl/block_aligner_pkg.sv
// Shared types and constants for the 64b/66b block aligner.
// Contents:
//   state_t       - aligner FSM states (HUNT, CONFIRM, LOCKED)
//   BLK_W/HDR_W   - 66-bit block made of a 2-bit sync header and a 64-bit payload
//   BUF_W         - width of the gearbox buffer shared with the seeker
//   HDR_DATA/CTRL - the two legal sync header codes
package blkalign_pkg;

    localparam int BLK_W   = 66;
    localparam int HDR_W   = 2;
    localparam int BUF_W   = 194;
    localparam int OFF_W   = 7;
    localparam int DATA_W  = BLK_W - HDR_W;
    // Coarse stage keeps one byte of slack so the fine stage can still shift by 0..7.
    localparam int SLICE_W = BLK_W + 7;

    localparam logic [HDR_W-1:0] HDR_DATA = 2'b01;
    localparam logic [HDR_W-1:0] HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic hdr_is_valid(input logic [HDR_W-1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/block_aligner_if.sv
// Bus bundle between the gearbox/seeker side and the block aligner.
// Inputs to the aligner:  gbox_buffer, buffer_dv, seek_synced, seek_offset
// Outputs of the aligner: blk_hdr_o, blk_data_o, blk_valid_o, locked_o,
//                         lock_offset_o, err_cnt_o, resync_o
// slave  - the aligner's view
// master - the view of whatever drives the gearbox and consumes blocks
interface block_aligner_if;
    import blkalign_pkg::*;

    logic [BUF_W-1:0]  gbox_buffer;
    logic              buffer_dv;
    logic              seek_synced;
    logic [OFF_W-1:0]  seek_offset;
    logic [HDR_W-1:0]  blk_hdr_o;
    logic [DATA_W-1:0] blk_data_o;
    logic              blk_valid_o;
    logic              locked_o;
    logic [OFF_W-1:0]  lock_offset_o;
    logic [4:0]        err_cnt_o;
    logic              resync_o;

    modport slave (
        input  gbox_buffer, buffer_dv, seek_synced, seek_offset,
        output blk_hdr_o, blk_data_o, blk_valid_o, locked_o,
               lock_offset_o, err_cnt_o, resync_o
    );

    modport master (
        output gbox_buffer, buffer_dv, seek_synced, seek_offset,
        input  blk_hdr_o, blk_data_o, blk_valid_o, locked_o,
               lock_offset_o, err_cnt_o, resync_o
    );

endinterface

// File: rtl/block_aligner_extract_pipe.sv
// Two-stage barrel shifter extracting a 66-bit block from the gearbox buffer.
// Stage 1 shifts by whole bytes (off[6:3]) and keeps a 73-bit slice; stage 2
// shifts by the remaining 0..7 bits. The offset and a sync tag ride along with
// each beat so the consumer sees exactly what the beat was captured with.
// Ports:
//   clk_i, rst_i - clock, async active-high reset
//   buf_i, dv_i  - gearbox buffer and its beat qualifier
//   off_i, tag_i - offset to apply to this beat, side-band flag carried along
//   hdr_o/data_o - extracted header/payload, qualified by valid_o
//   off_o, tag_o - offset and flag that belong to the emitted block
module blk_extract_pipe
    import blkalign_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BUF_W-1:0]  buf_i,
    input  logic              dv_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic              tag_i,
    output logic [HDR_W-1:0]  hdr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic [OFF_W-1:0]  off_o,
    output logic              tag_o
);

    logic [OFF_W-1:0]   coarse_base;
    logic [SLICE_W-1:0] coarse_slice;
    logic [BLK_W-1:0]   fine_blk;

    logic               s1_valid;
    logic [SLICE_W-1:0] s1_slice;
    logic [2:0]         s1_fine;
    logic [OFF_W-1:0]   s1_off;
    logic               s1_tag;

    // Largest base is 120 (off=127), so base+72 stays inside the 194-bit buffer.
    assign coarse_base  = {off_i[6:3], 3'b000};
    assign coarse_slice = buf_i[coarse_base +: SLICE_W];
    assign fine_blk     = s1_slice[s1_fine +: BLK_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_slice <= '0;
            s1_fine  <= '0;
            s1_off   <= '0;
            s1_tag   <= 1'b0;
            valid_o  <= 1'b0;
            hdr_o    <= '0;
            data_o   <= '0;
            off_o    <= '0;
            tag_o    <= 1'b0;
        end else begin
            s1_valid <= dv_i;
            if (dv_i) begin
                s1_slice <= coarse_slice;
                s1_fine  <= off_i[2:0];
                s1_off   <= off_i;
                s1_tag   <= tag_i;
            end
            valid_o <= s1_valid;
            if (s1_valid) begin
                {hdr_o, data_o} <= fine_blk;
                off_o           <= s1_off;
                tag_o           <= s1_tag;
            end
        end
    end

endmodule

// File: rtl/block_aligner.sv
// Block aligner: confirms the seeker's sync-header lock, freezes the offset,
// extracts aligned 66-bit blocks and drops lock when header errors pile up.
// Ports:
//   clk_i - system clock
//   rst_i - asynchronous, active-high reset
//   bus   - block_aligner_if.slave: gearbox buffer + seeker result in,
//           extracted blocks and lock status out
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | follow the seeker offset; wait for a synced beat with legal offset
// CONFIRM | offset frozen; count LOCK_CNT consecutive valid headers
// LOCKED  | offset frozen; count header errors per WIN_LEN-block window
module block_aligner
    import blkalign_pkg::*;
#(
    parameter int MAX_POS  = 65,
    parameter int LOCK_CNT = 32,
    parameter int WIN_LEN  = 1024,
    parameter int ERR_MAX  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    block_aligner_if.slave bus
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(WIN_LEN);
    localparam int ERR_W  = 5;
    localparam logic [ERR_W-1:0] ERR_SAT = '1;

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   lock_off_q, lock_off_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [WIN_W-1:0]   blk_q, blk_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               resync_q, resync_d;

    logic [OFF_W-1:0]   cap_off;
    logic               cap_tag;
    logic [HDR_W-1:0]   p_hdr;
    logic [DATA_W-1:0]  p_data;
    logic               p_valid;
    logic [OFF_W-1:0]   p_off;
    logic               p_tag;
    logic               p_hdr_ok;
    logic [ERR_W-1:0]   err_inc;
    logic [ERR_W-1:0]   err_next;
    logic               err_hit;

    // The tag marks a beat that may start CONFIRM. It is only raised for beats
    // captured in HUNT, so the offset it carries is always a seeker offset.
    assign cap_off = (state_q == HUNT) ? bus.seek_offset : lock_off_q;
    assign cap_tag = (state_q == HUNT) && bus.seek_synced
                     && (bus.seek_offset <= OFF_W'(MAX_POS));

    blk_extract_pipe u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .buf_i   (bus.gbox_buffer),
        .dv_i    (bus.buffer_dv),
        .off_i   (cap_off),
        .tag_i   (cap_tag),
        .hdr_o   (p_hdr),
        .data_o  (p_data),
        .valid_o (p_valid),
        .off_o   (p_off),
        .tag_o   (p_tag)
    );

    assign p_hdr_ok = hdr_is_valid(p_hdr);
    assign err_inc  = (err_q == ERR_SAT) ? err_q : err_q + ERR_W'(1);
    assign err_next = p_hdr_ok ? err_q : err_inc;
    assign err_hit  = (err_next >= ERR_W'(ERR_MAX));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= HUNT;
            lock_off_q <= '0;
            good_q     <= '0;
            blk_q      <= '0;
            err_q      <= '0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_off_q <= lock_off_d;
            good_q     <= good_d;
            blk_q      <= blk_d;
            err_q      <= err_d;
            resync_q   <= resync_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_off_d = lock_off_q;
        good_d     = good_q;
        blk_d      = blk_q;
        err_d      = err_q;
        resync_d   = 1'b0;

        if (p_valid) begin
            case (state_q)
                HUNT: begin
                    if (p_tag) begin
                        lock_off_d = p_off;
                        good_d     = '0;
                        state_d    = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (!p_hdr_ok) begin
                        // Seeker is still running, so no resync request here.
                        state_d = HUNT;
                    end else begin
                        good_d = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            blk_d   = '0;
                            err_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    // Loss of lock wins over a window wrap on the same beat.
                    if (err_hit) begin
                        state_d  = HUNT;
                        err_d    = err_next;
                        resync_d = 1'b1;
                    end else if (blk_q == WIN_W'(WIN_LEN - 1)) begin
                        blk_d = '0;
                        err_d = '0;
                    end else begin
                        blk_d = blk_q + WIN_W'(1);
                        err_d = err_next;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.blk_hdr_o     = p_hdr;
    assign bus.blk_data_o    = p_data;
    assign bus.blk_valid_o   = p_valid;
    assign bus.locked_o      = (state_q == LOCKED);
    assign bus.lock_offset_o = lock_off_q;
    assign bus.err_cnt_o     = err_q;
    assign bus.resync_o      = resync_q;

endmodule

// File: tb/tb_block_aligner.sv
// Directed testbench for block_aligner. Beat k is driven at negedge k; its
// block appears at negedge k+2 and the FSM reaction to it at negedge k+3.
module tb_block_aligner;
    import blkalign_pkg::*;

    localparam int NB = 4096;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    block_aligner_if bus_if ();

    block_aligner dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [1:0]  t_hdr  [NB];
    logic [63:0] t_data [NB];
    logic        t_dv   [NB];
    logic        t_sync [NB];
    int          t_off  [NB];

    function automatic logic [193:0] mk_buf(input int off, input logic [1:0] h, input logic [63:0] d);
        logic [223:0] f;
        logic [193:0] b;
        f = {~d, d, ~d, d[31:0]};
        b = f[193:0];
        b[off +: 66] = {h, d};
        return b;
    endfunction

    // Errors counted in the current window after the last evaluated beat (k-3);
    // locked beats start at beat 33, one window is 1024 beats.
    function automatic int exp_err(input int k);
        int last, rel, n;
        last = k - 3;
        n = 0;
        if (last < 33) return 0;
        rel = (last - 33) % 1024;
        if (rel == 1023) return 0;
        for (int b = last - rel; b <= last; b++)
            if (t_hdr[b] != HDR_DATA && t_hdr[b] != HDR_CTRL) n++;
        return n;
    endfunction

    task automatic fill_clean(input int n, input int off);
        for (int i = 0; i < NB; i++) begin
            t_dv[i]   = (i < n);
            t_sync[i] = 1'b0;
            t_off[i]  = off;
            t_hdr[i]  = i[0] ? HDR_CTRL : HDR_DATA;
            t_data[i] = {32'(i) ^ 32'hA5A5_0000, 32'(i) * 32'h0100_0193};
        end
    endtask

    task automatic drive_beat(input int k);
        bus_if.gbox_buffer = mk_buf(t_off[k], t_hdr[k], t_data[k]);
        bus_if.buffer_dv   = t_dv[k];
        bus_if.seek_synced = t_sync[k];
        bus_if.seek_offset = 7'(t_off[k]);
    endtask

    task automatic drive_idle();
        bus_if.gbox_buffer = '0;
        bus_if.buffer_dv   = 1'b0;
        bus_if.seek_synced = 1'b0;
        bus_if.seek_offset = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        @(negedge clk_i);
        total++;
        if ({bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o, bus_if.blk_hdr_o,
             bus_if.blk_data_o, bus_if.lock_offset_o, bus_if.err_cnt_o} !== '0) begin
            bad++;
            $display("FAIL reset_hold got v=%b l=%b r=%b h=%b d=%h off=%0d err=%0d required all 0",
                     bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o, bus_if.blk_hdr_o,
                     bus_if.blk_data_o, bus_if.lock_offset_o, bus_if.err_cnt_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o, bus_if.blk_hdr_o,
             bus_if.blk_data_o, bus_if.lock_offset_o, bus_if.err_cnt_o} !== '0) begin
            bad++;
            $display("FAIL reset_release got v=%b l=%b r=%b off=%0d err=%0d required all 0",
                     bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o,
                     bus_if.lock_offset_o, bus_if.err_cnt_o);
        end
    endtask

    task automatic test_lock_17();
        do_reset();
        fill_clean(40, 17);
        for (int i = 0; i < 40; i++) t_sync[i] = 1'b1;
        for (int k = 0; k < 43; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL lock17_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL lock17_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== (k >= 35)) begin
                bad++;
                $display("FAIL lock17_locked k=%0d got %b required %b", k, bus_if.locked_o, (k >= 35));
            end
            total++;
            if (bus_if.resync_o !== 1'b0) begin
                bad++;
                $display("FAIL lock17_resync k=%0d got %b required 0", k, bus_if.resync_o);
            end
            drive_beat(k);
        end
        drive_idle();
        total++;
        if (bus_if.lock_offset_o !== 7'd17) begin
            bad++;
            $display("FAIL lock17_offset got %0d required 17", bus_if.lock_offset_o);
        end
    endtask

    task automatic test_offset_65();
        do_reset();
        fill_clean(40, 65);
        t_sync[0] = 1'b1;
        t_hdr[5]  = 2'b01;
        t_data[5] = 64'hDEADBEEF_01234567;
        for (int k = 0; k < 43; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL off65_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL off65_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            if (k == 7) begin
                total++;
                if (bus_if.blk_hdr_o !== 2'b01 || bus_if.blk_data_o !== 64'hDEADBEEF_01234567) begin
                    bad++;
                    $display("FAIL off65_deadbeef got h=%b d=%h required h=01 d=deadbeef01234567",
                             bus_if.blk_hdr_o, bus_if.blk_data_o);
                end
            end
            drive_beat(k);
        end
        drive_idle();
        total++;
        if (bus_if.locked_o !== 1'b1 || bus_if.lock_offset_o !== 7'd65) begin
            bad++;
            $display("FAIL off65_lock got l=%b off=%0d required l=1 off=65", bus_if.locked_o, bus_if.lock_offset_o);
        end
    endtask

    task automatic test_illegal_offset();
        do_reset();
        fill_clean(40, 70);
        for (int i = 0; i < 40; i++) t_sync[i] = 1'b1;
        for (int k = 0; k < 43; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL off70_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL off70_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== 1'b0) begin
                bad++;
                $display("FAIL off70_locked k=%0d got %b required 0", k, bus_if.locked_o);
            end
            drive_beat(k);
        end
        drive_idle();
        total++;
        if (bus_if.lock_offset_o !== 7'd0) begin
            bad++;
            $display("FAIL off70_offset got %0d required 0", bus_if.lock_offset_o);
        end
    endtask

    task automatic test_confirm_err();
        do_reset();
        fill_clean(50, 17);
        t_sync[0] = 1'b1;
        t_hdr[10] = 2'b00;
        for (int k = 0; k < 53; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL conf_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL conf_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== 1'b0 || bus_if.resync_o !== 1'b0) begin
                bad++;
                $display("FAIL conf_err k=%0d got l=%b r=%b required l=0 r=0", k, bus_if.locked_o, bus_if.resync_o);
            end
            drive_beat(k);
        end
        drive_idle();
        total++;
        if (bus_if.lock_offset_o !== 7'd17) begin
            bad++;
            $display("FAIL conf_offset got %0d required 17", bus_if.lock_offset_o);
        end
    endtask

    task automatic test_loss_of_lock();
        int n, pulses;
        n = 33 + 1031;
        pulses = 0;
        do_reset();
        fill_clean(n, 17);
        t_sync[0] = 1'b1;
        for (int j = 0; j < 15; j++) t_hdr[33 + 50*j + 10] = 2'b11;
        t_hdr[33 + 1023] = 2'b11;
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL loss_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL loss_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== (k >= 35 && k < 1059)) begin
                bad++;
                $display("FAIL loss_locked k=%0d got %b required %b", k, bus_if.locked_o, (k >= 35 && k < 1059));
            end
            total++;
            if (bus_if.resync_o !== (k == 1059)) begin
                bad++;
                $display("FAIL loss_resync k=%0d got %b required %b", k, bus_if.resync_o, (k == 1059));
            end
            if (bus_if.resync_o === 1'b1) pulses++;
            if (k >= 35 && k < 1059) begin
                total++;
                if (bus_if.err_cnt_o !== 5'(exp_err(k))) begin
                    bad++;
                    $display("FAIL loss_errcnt k=%0d got %0d required %0d", k, bus_if.err_cnt_o, exp_err(k));
                end
            end
            drive_beat(k);
        end
        drive_idle();
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL loss_pulses got %0d required 1", pulses);
        end
    endtask

    task automatic test_windows();
        int n;
        n = 33 + 3*1024 + 4;
        do_reset();
        fill_clean(n, 17);
        t_sync[0] = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int j = 0; j < 14; j++) t_hdr[33 + 1024*w + 60*j + 5] = 2'b11;
            t_hdr[33 + 1024*w + 1023] = 2'b11;
        end
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL win_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL win_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== (k >= 35) || bus_if.resync_o !== 1'b0) begin
                bad++;
                $display("FAIL win_lock k=%0d got l=%b r=%b required l=%b r=0", k, bus_if.locked_o, bus_if.resync_o, (k >= 35));
            end
            if (k >= 35) begin
                total++;
                if (bus_if.err_cnt_o !== 5'(exp_err(k))) begin
                    bad++;
                    $display("FAIL win_errcnt k=%0d got %0d required %0d", k, bus_if.err_cnt_o, exp_err(k));
                end
            end
            drive_beat(k);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        fill_clean(60, 17);
        t_sync[0] = 1'b1;
        for (int k = 0; k < 41; k++) begin
            @(negedge clk_i);
            total++;
            if (k >= 2 && t_dv[k-2]) begin
                if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[k-2] || bus_if.blk_data_o !== t_data[k-2]) begin
                    bad++;
                    $display("FAIL mid_blk k=%0d got v=%b h=%b d=%h required v=1 h=%b d=%h",
                             k, bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[k-2], t_data[k-2]);
                end
            end else if (bus_if.blk_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL mid_idle k=%0d got v=%b required 0", k, bus_if.blk_valid_o);
            end
            total++;
            if (bus_if.locked_o !== (k >= 35)) begin
                bad++;
                $display("FAIL mid_locked k=%0d got %b required %b", k, bus_if.locked_o, (k >= 35));
            end
            drive_beat(k);
        end
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        total++;
        if ({bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o, bus_if.blk_hdr_o,
             bus_if.blk_data_o, bus_if.lock_offset_o, bus_if.err_cnt_o} !== '0) begin
            bad++;
            $display("FAIL mid_async got v=%b l=%b r=%b h=%b d=%h off=%0d err=%0d required all 0",
                     bus_if.blk_valid_o, bus_if.locked_o, bus_if.resync_o, bus_if.blk_hdr_o,
                     bus_if.blk_data_o, bus_if.lock_offset_o, bus_if.err_cnt_o);
        end
        @(negedge clk_i);
        drive_idle();
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if (bus_if.blk_valid_o !== 1'b0 || bus_if.locked_o !== 1'b0) begin
                bad++;
                $display("FAIL mid_after i=%0d got v=%b l=%b required v=0 l=0", i, bus_if.blk_valid_o, bus_if.locked_o);
            end
        end
        drive_beat(0);
        @(negedge clk_i);
        drive_idle();
        total++;
        if (bus_if.blk_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_lat1 got v=%b required 0", bus_if.blk_valid_o);
        end
        @(negedge clk_i);
        total++;
        if (bus_if.blk_valid_o !== 1'b1 || bus_if.blk_hdr_o !== t_hdr[0] || bus_if.blk_data_o !== t_data[0]) begin
            bad++;
            $display("FAIL mid_newbeat got v=%b h=%b d=%h required v=1 h=%b d=%h",
                     bus_if.blk_valid_o, bus_if.blk_hdr_o, bus_if.blk_data_o, t_hdr[0], t_data[0]);
        end
        @(negedge clk_i);
        total++;
        if (bus_if.blk_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_single got v=%b required 0", bus_if.blk_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_lock_17();
        test_offset_65();
        test_illegal_offset();
        test_confirm_err();
        test_loss_of_lock();
        test_windows();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_aligner.md
Name: block_aligner

Overview:
- Downstream stage of the hierarchical sync-header seeker in the Aurora 64b/66b receive path.
- Consumes the seeker's is_synced/offset_pos together with the same gearbox buffer.
- Confirms the lock, freezes the winning offset, and extracts aligned 66-bit blocks as a 2-bit header plus 64-bit payload.
- Monitors header errors and drops lock, requesting a re-seek, when the link degrades.

Parameters:
- MAX_POS, 65, largest legal offset; offsets above this are illegal.
- LOCK_CNT, 32, consecutive valid headers needed at the frozen offset to declare lock.
- WIN_LEN, 1024, monitoring window length in blocks while locked.
- ERR_MAX, 16, invalid headers within one window that cause loss of lock.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-high
- gbox_buffer  in  194  gearbox buffer, same bus the seeker sees
- buffer_dv  in  1  one new 66-bit block is present in gbox_buffer this cycle
- seek_synced  in  1  is_synced from seeker
- seek_offset  in  7  offset_pos from seeker
- blk_hdr_o  out  2  extracted sync header
- blk_data_o  out  64  extracted payload
- blk_valid_o  out  1  one-cycle qualifier for blk_hdr_o/blk_data_o
- locked_o  out  1  FSM is in LOCKED
- lock_offset_o  out  7  frozen offset in use
- err_cnt_o  out  5  invalid headers counted in the current window (saturating)
- resync_o  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted and after release, every output is 0, the FSM is in HUNT, and all counters and pipeline valids are 0.
- Extraction:
  - blk = gbox_buffer[off +: 66], where off is the frozen offset in CONFIRM/LOCKED and seek_offset in HUNT.
  - blk_hdr_o = blk[65:64]; blk_data_o = blk[63:0].
  - The shifter has two stages. Stage 1 shifts coarsely by off[6:3]*8 and keeps a 73-bit slice. Stage 2 shifts finely by off[2:0].
  - Latency is exactly 2 cycles from buffer_dv to blk_valid_o. Throughput is one block per cycle.
  - off is sampled together with the gbox_buffer beat it applies to and travels down the pipe with that beat.
- A header is valid iff it is 2'b01 or 2'b10. Blocks are emitted in every state. Consumers qualify them with locked_o.
- FSM events are evaluated only on stage-2 valid beats.
  - HUNT: when seek_synced=1 on a buffer_dv beat, latch seek_offset into lock_offset_o, clear good_cnt, and go to CONFIRM.
  - CONFIRM:
    - A valid header increments good_cnt. When good_cnt reaches LOCK_CNT, go to LOCKED, clear blk_cnt and err_cnt_o, and set locked_o.
    - Any invalid header returns to HUNT. resync_o is not pulsed here; the seeker is still running.
  - LOCKED:
    - Each beat increments blk_cnt. An invalid header increments err_cnt_o, saturating at 31.
    - If err_cnt_o reaches ERR_MAX (evaluated including the current beat), go to HUNT, clear locked_o, and pulse resync_o for 1 cycle.
    - Otherwise, when blk_cnt wraps at WIN_LEN-1, clear blk_cnt and err_cnt_o. If this coincides with the error that reaches ERR_MAX, loss of lock takes priority.
    - Changes on seek_offset/seek_synced are ignored while in LOCKED.
- A seek_offset greater than MAX_POS in HUNT is treated as seek_synced=0.
- Beats already in flight when the FSM changes state still emit. They use the offset they were captured with.
- Reset asserted mid-operation forces HUNT immediately and kills in-flight valids.

Decomposition:
- Package blkalign_pkg holds:
  - state enum {HUNT, CONFIRM, LOCKED};
  - constants BLK_W=66, HDR_W=2, BUF_W=194;
  - HDR_DATA=2'b01, HDR_CTRL=2'b10.
- The shifter is its own sub-module, blk_extract_pipe (2-stage shifter plus valid/offset pipe). The FSM and counters stay in the top.

Test Plan:
- Clean stream at offset 17, seek_synced rising on the first beat:
  - locked_o rises 2+32 beats later;
  - lock_offset_o=17;
  - blk_data_o matches the injected payload with 2-cycle latency.
- Offset 65 (upper boundary) with payload 64'hDEADBEEF_01234567 -> extracted exactly, blk_hdr_o=2'b01.
- In CONFIRM, inject an invalid header (2'b00) on beat 10 -> return to HUNT, no resync_o pulse, locked_o stays 0.
- While locked, inject 16 headers of 2'b11 within 1024 blocks -> resync_o pulses once on the 16th, then locked_o=0 and HUNT.
- While locked, inject 15 errors per window over 3 windows -> lock held, err_cnt_o returns to 0 at each wrap.
- Assert rst_i asynchronously (mid-clock) while LOCKED with beats in flight -> all outputs 0 immediately, no blk_valid_o after release until new buffer_dv.
